// File: rtl/simple_if_bus_if.sv
// Interface bundling the driver, consumer and checker signals of simple_if_bus.
// Optional parity signals exist only when SIMPLE_IF_PARITY_EN is defined.
interface simple_if_bus_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 8
);
  // driver side
  logic             drv_we;
  logic [DW-1:0]    drv_data;
  logic             drv_valid;
  // channel registers and consumer view
  logic [DW-1:0]    bus_data;
  logic             bus_valid;
  logic [DW-1:0]    cap_data;
  logic             cap_valid;
  // checker
  logic             chk_en;
  logic [DW-1:0]    exp_data;
  logic             exp_valid;
  logic             chk_done;
  logic             chk_fail;
  logic             fail_seen;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
`ifdef SIMPLE_IF_PARITY_EN
  logic             bus_par;
  logic             exp_par;
`endif

  // producer / test side: drives strobes and expectations
  modport master (
    output drv_we, drv_data, drv_valid,
    output chk_en, exp_data, exp_valid,
`ifdef SIMPLE_IF_PARITY_EN
    output exp_par,
    input  bus_par,
`endif
    input  bus_data, bus_valid, cap_data, cap_valid,
    input  chk_done, chk_fail, fail_seen, pass_cnt, fail_cnt
  );

  // channel / monitor side
  modport slave (
    input  drv_we, drv_data, drv_valid,
    input  chk_en, exp_data, exp_valid,
`ifdef SIMPLE_IF_PARITY_EN
    input  exp_par,
    output bus_par,
`endif
    output bus_data, bus_valid, cap_data, cap_valid,
    output chk_done, chk_fail, fail_seen, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/simple_if_bus.sv
// simple_if_bus: registered data/valid channel with a built-in checker.
// Driver writes load bus_data/bus_valid together; consumers see a zero-latency
// copy. A check request compares the current channel value against an
// expected value and reports a one-cycle done/fail pulse plus saturating
// pass/fail counters and a sticky fail flag.
// Optional feature macro: SIMPLE_IF_PARITY_EN (adds registered bus_par and
// an exp_par comparison).
module simple_if_bus #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  simple_if_bus_if.slave   bus
);

  logic [DW-1:0]    bus_data_q,  bus_data_d;
  logic             bus_valid_q, bus_valid_d;
  logic             chk_done_q,  chk_done_d;
  logic             chk_fail_q,  chk_fail_d;
  logic             fail_seen_q, fail_seen_d;
  logic [CNT_W-1:0] pass_cnt_q,  pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q,  fail_cnt_d;
  logic             mismatch;
`ifdef SIMPLE_IF_PARITY_EN
  logic             bus_par_q,   bus_par_d;
`endif

  // Channel registers: both fields (and parity) load as one unit on drv_we.
  always_comb begin
    bus_data_d  = bus_data_q;
    bus_valid_d = bus_valid_q;
`ifdef SIMPLE_IF_PARITY_EN
    bus_par_d   = bus_par_q;
`endif
    if (bus.drv_we) begin
      bus_data_d  = bus.drv_data;
      bus_valid_d = bus.drv_valid;
`ifdef SIMPLE_IF_PARITY_EN
      bus_par_d   = ^{bus.drv_valid, bus.drv_data};
`endif
    end
  end

  // Compare the pre-edge channel value, so a same-cycle write is not seen.
  always_comb begin
    mismatch = (bus_data_q != bus.exp_data) || (bus_valid_q != bus.exp_valid);
`ifdef SIMPLE_IF_PARITY_EN
    mismatch = mismatch || (bus_par_q != bus.exp_par);
`endif
  end

  // Checker result pulses, sticky fail flag and saturating counters.
  always_comb begin
    chk_done_d  = 1'b0;
    chk_fail_d  = 1'b0;
    fail_seen_d = fail_seen_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    if (bus.chk_en) begin
      chk_done_d = 1'b1;
      if (mismatch) begin
        chk_fail_d  = 1'b1;
        fail_seen_d = 1'b1;
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end else begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset overrides any write or check in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      chk_done_q  <= 1'b0;
      chk_fail_q  <= 1'b0;
      fail_seen_q <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
`ifdef SIMPLE_IF_PARITY_EN
      bus_par_q   <= 1'b0;
`endif
    end else begin
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      chk_done_q  <= chk_done_d;
      chk_fail_q  <= chk_fail_d;
      fail_seen_q <= fail_seen_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
`ifdef SIMPLE_IF_PARITY_EN
      bus_par_q   <= bus_par_d;
`endif
    end
  end

  assign bus.bus_data  = bus_data_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.cap_data  = bus_data_q;
  assign bus.cap_valid = bus_valid_q;
  assign bus.chk_done  = chk_done_q;
  assign bus.chk_fail  = chk_fail_q;
  assign bus.fail_seen = fail_seen_q;
  assign bus.pass_cnt  = pass_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
`ifdef SIMPLE_IF_PARITY_EN
  assign bus.bus_par   = bus_par_q;
`endif

endmodule

// File: tb/tb_simple_if_bus.sv
// Directed self-checking bench for simple_if_bus.
// Honours SIMPLE_IF_PARITY_EN when defined (drives exp_par, checks bus_par).
module tb_simple_if_bus;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  simple_if_bus_if #(.DW(8), .CNT_W(8)) bif ();

  simple_if_bus #(.DW(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic we, input logic [7:0] d, input logic v);
    bif.drv_we    = we;
    bif.drv_data  = d;
    bif.drv_valid = v;
  endtask

  task automatic set_check(input logic en, input logic [7:0] d, input logic v);
    bif.chk_en    = en;
    bif.exp_data  = d;
    bif.exp_valid = v;
`ifdef SIMPLE_IF_PARITY_EN
    bif.exp_par   = ^{v, d};
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_write(1'b1, 8'h77, 1'b1);
    set_check(1'b0, 8'h00, 1'b0);
    tick();
    set_check(1'b1, 8'h11, 1'b1);   // request during reset must be dropped
    tick();
    rst = 1'b0;
    set_write(1'b0, 8'h00, 1'b0);
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (bif.bus_data !== 8'h00) begin errors++; $display("FAIL reset_bus_data got=%h exp=00", bif.bus_data); end
    checks++; if (bif.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid got=%b exp=0", bif.bus_valid); end
    checks++; if (bif.chk_done !== 1'b0) begin errors++; $display("FAIL reset_chk_done got=%b exp=0", bif.chk_done); end
    checks++; if (bif.pass_cnt !== 8'h00 || bif.fail_cnt !== 8'h00) begin
      errors++; $display("FAIL reset_counters got=%h/%h exp=00/00", bif.pass_cnt, bif.fail_cnt); end
    checks++; if (bif.fail_seen !== 1'b0) begin errors++; $display("FAIL reset_fail_seen got=%b exp=0", bif.fail_seen); end
`ifdef SIMPLE_IF_PARITY_EN
    checks++; if (bif.bus_par !== 1'b0) begin errors++; $display("FAIL reset_bus_par got=%b exp=0", bif.bus_par); end
`endif
  endtask

  task automatic test_write_check();
    set_write(1'b1, 8'hAB, 1'b1);
    tick();
    set_write(1'b0, 8'h00, 1'b0);
    checks++; if (bif.cap_data !== 8'hAB || bif.cap_valid !== 1'b1) begin
      errors++; $display("FAIL cap_view got=%h/%b exp=AB/1", bif.cap_data, bif.cap_valid); end
`ifdef SIMPLE_IF_PARITY_EN
    checks++; if (bif.bus_par !== 1'b0) begin errors++; $display("FAIL bus_par_AB got=%b exp=0", bif.bus_par); end
`endif
    set_check(1'b1, 8'hAB, 1'b1);
    tick();
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (bif.chk_done !== 1'b1 || bif.chk_fail !== 1'b0) begin
      errors++; $display("FAIL check_AB done/fail got=%b/%b exp=1/0", bif.chk_done, bif.chk_fail); end
    checks++; if (bif.pass_cnt !== 8'd1) begin errors++; $display("FAIL pass_cnt_1 got=%0d exp=1", bif.pass_cnt); end
    tick();
    checks++; if (bif.chk_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", bif.chk_done); end
  endtask

  task automatic test_sequence();
    set_write(1'b1, 8'hCD, 1'b0);
    tick();
    set_write(1'b0, 8'h00, 1'b0);
    set_check(1'b1, 8'hCD, 1'b0);
    tick();
    set_check(1'b0, 8'h00, 1'b0);
    set_write(1'b1, 8'h00, 1'b0);
    tick();
    set_write(1'b0, 8'h00, 1'b0);
    set_check(1'b1, 8'h00, 1'b0);
    tick();
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (bif.pass_cnt !== 8'd3) begin errors++; $display("FAIL pass_cnt_3 got=%0d exp=3", bif.pass_cnt); end
    checks++; if (bif.fail_seen !== 1'b0) begin errors++; $display("FAIL fail_seen_clean got=%b exp=0", bif.fail_seen); end
  endtask

  task automatic test_fail();
    set_check(1'b1, 8'h00, 1'b1);
    tick();
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (bif.chk_done !== 1'b1 || bif.chk_fail !== 1'b1) begin
      errors++; $display("FAIL mismatch_pulse got=%b/%b exp=1/1", bif.chk_done, bif.chk_fail); end
    checks++; if (bif.fail_cnt !== 8'd1 || bif.pass_cnt !== 8'd3) begin
      errors++; $display("FAIL counts_after_fail got=%0d/%0d exp=3/1", bif.pass_cnt, bif.fail_cnt); end
    checks++; if (bif.fail_seen !== 1'b1) begin errors++; $display("FAIL fail_seen_set got=%b exp=1", bif.fail_seen); end
    set_check(1'b1, 8'h00, 1'b0);
    tick();
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (bif.chk_fail !== 1'b0 || bif.pass_cnt !== 8'd4) begin
      errors++; $display("FAIL pass_after_fail got=%b/%0d exp=0/4", bif.chk_fail, bif.pass_cnt); end
    checks++; if (bif.fail_seen !== 1'b1) begin errors++; $display("FAIL fail_seen_sticky got=%b exp=1", bif.fail_seen); end
  endtask

  task automatic test_same_cycle();
    set_write(1'b1, 8'h5A, 1'b1);
    set_check(1'b1, 8'h00, 1'b0);   // old channel value
    tick();
    set_write(1'b0, 8'h00, 1'b0);
    checks++; if (bif.chk_fail !== 1'b0 || bif.pass_cnt !== 8'd5) begin
      errors++; $display("FAIL same_cycle_old got=%b/%0d exp=0/5", bif.chk_fail, bif.pass_cnt); end
    checks++; if (bif.bus_data !== 8'h5A || bif.bus_valid !== 1'b1) begin
      errors++; $display("FAIL same_cycle_write got=%h/%b exp=5A/1", bif.bus_data, bif.bus_valid); end
    set_check(1'b1, 8'h5A, 1'b1);
    tick();
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (bif.chk_done !== 1'b1 || bif.chk_fail !== 1'b0 || bif.pass_cnt !== 8'd6) begin
      errors++; $display("FAIL next_cycle_new got=%b/%b/%0d exp=1/0/6", bif.chk_done, bif.chk_fail, bif.pass_cnt); end
  endtask

  task automatic test_hold();
    set_write(1'b0, 8'hFF, 1'b0);   // data on the bus but no strobe
    repeat (5) tick();
    checks++; if (bif.bus_data !== 8'h5A || bif.bus_valid !== 1'b1) begin
      errors++; $display("FAIL hold got=%h/%b exp=5A/1", bif.bus_data, bif.bus_valid); end
    set_write(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    int missing;
    missing = 0;
    set_check(1'b1, 8'h5A, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bif.chk_done !== 1'b1 || bif.chk_fail !== 1'b0) missing++;
      if (i == 248) begin
        checks++; if (bif.pass_cnt !== 8'd254) begin errors++; $display("FAIL pass_cnt_254 got=%0d exp=254", bif.pass_cnt); end
      end
      if (i == 249) begin
        checks++; if (bif.pass_cnt !== 8'd255) begin errors++; $display("FAIL pass_cnt_255 got=%0d exp=255", bif.pass_cnt); end
      end
    end
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (missing != 0) begin errors++; $display("FAIL back_to_back_pulses got=%0d bad exp=0 bad", missing); end
    checks++; if (bif.pass_cnt !== 8'hFF || bif.fail_cnt !== 8'd1) begin
      errors++; $display("FAIL saturate got=%h/%h exp=FF/01", bif.pass_cnt, bif.fail_cnt); end
  endtask

  task automatic test_reset_mid();
    set_check(1'b1, 8'h00, 1'b1);   // would fail if not dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_check(1'b0, 8'h00, 1'b0);
    checks++; if (bif.chk_done !== 1'b0 || bif.chk_fail !== 1'b0) begin
      errors++; $display("FAIL reset_drops_check got=%b/%b exp=0/0", bif.chk_done, bif.chk_fail); end
    checks++; if (bif.pass_cnt !== 8'h00 || bif.fail_cnt !== 8'h00 || bif.fail_seen !== 1'b0) begin
      errors++; $display("FAIL reset_clears got=%h/%h/%b exp=00/00/0", bif.pass_cnt, bif.fail_cnt, bif.fail_seen); end
    checks++; if (bif.bus_data !== 8'h00 || bif.bus_valid !== 1'b0) begin
      errors++; $display("FAIL reset_clears_bus got=%h/%b exp=00/0", bif.bus_data, bif.bus_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    set_write(1'b0, 8'h00, 1'b0);
    set_check(1'b0, 8'h00, 1'b0);
    test_reset();
    test_write_check();
    test_sequence();
    test_fail();
    test_same_cycle();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
